// File: rtl/skin_pkg.sv
// Shared definitions for the skin-detection threshold controller:
// register map, default threshold bounds, counter width and frame FSM states.
package skin_pkg;

    // Shadow register map (cfg_addr values)
    localparam logic [2:0] ADDR_Y_MIN  = 3'd0;
    localparam logic [2:0] ADDR_Y_MAX  = 3'd1;
    localparam logic [2:0] ADDR_CB_MIN = 3'd2;
    localparam logic [2:0] ADDR_CB_MAX = 3'd3;
    localparam logic [2:0] ADDR_CR_MIN = 3'd4;
    localparam logic [2:0] ADDR_CR_MAX = 3'd5;
    localparam int         NUM_THR     = 6;

    // Default threshold bounds
    localparam int Y_MIN_DEF  = 80;
    localparam int Y_MAX_DEF  = 235;
    localparam int CB_MIN_DEF = 85;
    localparam int CB_MAX_DEF = 135;
    localparam int CR_MIN_DEF = 135;
    localparam int CR_MAX_DEF = 180;

    // Pixel counter width, enough for a 640x480 frame
    localparam int CNT_W = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DONE  = 2'd2
    } frame_state_t;

    // Addresses 6 and 7 are unmapped
    function automatic logic addr_is_valid(input logic [2:0] addr);
        return addr <= ADDR_CR_MAX;
    endfunction

endpackage

// File: rtl/skin_frame_stats.sv
// Per-frame pixel / skin-pixel counters with saturation, plus the publish
// registers that hold the last completed frame's totals. Only built when
// SKIN_STATS_EN is defined.
module skin_frame_stats
    import skin_pkg::*;
#(
    parameter int CNT_W = skin_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             pix_inc,
    input  logic             skin_inc,
    input  logic             publish,
    output logic [CNT_W-1:0] pix_count,
    output logic [CNT_W-1:0] skin_count,
    output logic             stats_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pix_reg, pix_next;
    logic [CNT_W-1:0] skin_reg, skin_next;
    logic             sat_reg, sat_next;
    logic [CNT_W-1:0] pix_pub_reg, skin_pub_reg;
    logic             sat_pub_reg;

    // Next working counts: clear wins, otherwise saturating increments
    always_comb begin
        pix_next  = pix_reg;
        skin_next = skin_reg;
        sat_next  = sat_reg;
        if (clr) begin
            pix_next  = '0;
            skin_next = '0;
            sat_next  = 1'b0;
        end else begin
            if (pix_inc) begin
                if (pix_reg == CNT_MAX) sat_next = 1'b1;
                else                    pix_next = pix_reg + 1'b1;
            end
            if (skin_inc) begin
                if (skin_reg == CNT_MAX) sat_next  = 1'b1;
                else                     skin_next = skin_reg + 1'b1;
            end
        end
    end

    // Working counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_reg  <= '0;
            skin_reg <= '0;
            sat_reg  <= 1'b0;
        end else begin
            pix_reg  <= pix_next;
            skin_reg <= skin_next;
            sat_reg  <= sat_next;
        end
    end

    // Publish includes the pixel arriving with eof, hence the next values
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_pub_reg  <= '0;
            skin_pub_reg <= '0;
            sat_pub_reg  <= 1'b0;
        end else if (publish) begin
            pix_pub_reg  <= pix_next;
            skin_pub_reg <= skin_next;
            sat_pub_reg  <= sat_next;
        end
    end

    assign pix_count  = pix_pub_reg;
    assign skin_count = skin_pub_reg;
    assign stats_sat  = sat_pub_reg;

endmodule

// File: rtl/skin_thresh_ctrl.sv
// Frame-synchronous threshold controller for the YCbCr skin detector.
// Shadow thresholds are committed atomically to the active set at sof;
// per-frame statistics are published one cycle after eof.
// Build option: SKIN_STATS_EN enables the pixel/skin counters; without it
// pix_count, skin_count and stats_sat are tied to zero.
module skin_thresh_ctrl
    import skin_pkg::*;
#(
    parameter int Y_MIN_RST  = skin_pkg::Y_MIN_DEF,
    parameter int Y_MAX_RST  = skin_pkg::Y_MAX_DEF,
    parameter int CB_MIN_RST = skin_pkg::CB_MIN_DEF,
    parameter int CB_MAX_RST = skin_pkg::CB_MAX_DEF,
    parameter int CR_MIN_RST = skin_pkg::CR_MIN_DEF,
    parameter int CR_MAX_RST = skin_pkg::CR_MAX_DEF,
    parameter int CNT_W      = skin_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr_valid,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    input  logic             cfg_commit,
    input  logic             sof,
    input  logic             eof,
    input  logic             pix_valid,
    input  logic             skin_mask,
    output logic [7:0]       thr_y_min,
    output logic [7:0]       thr_y_max,
    output logic [7:0]       thr_cb_min,
    output logic [7:0]       thr_cb_max,
    output logic [7:0]       thr_cr_min,
    output logic [7:0]       thr_cr_max,
    output logic             commit_pending,
    output logic             cfg_err,
    output logic             frame_err,
    output logic             frame_done,
    output logic [CNT_W-1:0] pix_count,
    output logic [CNT_W-1:0] skin_count,
    output logic             stats_sat
);

    localparam logic [NUM_THR-1:0][7:0] RST_VAL = {
        8'(CR_MAX_RST), 8'(CR_MIN_RST), 8'(CB_MAX_RST),
        8'(CB_MIN_RST), 8'(Y_MAX_RST),  8'(Y_MIN_RST)
    };

    logic [NUM_THR-1:0][7:0] shadow_reg;
    logic [NUM_THR-1:0][7:0] active_reg;
    logic                    pending_reg;
    logic                    cfg_err_reg;
    logic                    frame_err_reg;
    logic                    frame_done_reg;
    frame_state_t            state_reg;

    logic [2:0] pair_ok;
    logic       bounds_ok;
    logic       commit_fire;
    logic       wr_ok;
    logic       wr_bad;

    // Each min/max pair must be ordered for a commit to be accepted
    for (genvar gi = 0; gi < 3; gi++) begin : g_pair
        assign pair_ok[gi] = shadow_reg[2*gi] <= shadow_reg[2*gi+1];
    end
    assign bounds_ok = &pair_ok;

    // A commit requested in the sof cycle itself is honoured immediately
    assign commit_fire = sof & (pending_reg | cfg_commit);
    assign wr_ok       = cfg_wr_valid &  addr_is_valid(cfg_addr);
    assign wr_bad      = cfg_wr_valid & ~addr_is_valid(cfg_addr);

    // Shadow writes; a write alongside a commit lands after the copy
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= RST_VAL;
        end else begin
            for (int i = 0; i < NUM_THR; i++) begin
                if (wr_ok && cfg_addr == 3'(i)) shadow_reg[i] <= cfg_wdata;
            end
        end
    end

    // Atomic shadow-to-active copy at sof
    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg <= RST_VAL;
        end else if (commit_fire && bounds_ok) begin
            active_reg <= shadow_reg;
        end
    end

    // Commit arming and configuration error flag (a new error beats a clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            if (commit_fire)     pending_reg <= 1'b0;
            else if (cfg_commit) pending_reg <= 1'b1;

            if (wr_bad || (commit_fire && !bounds_ok)) cfg_err_reg <= 1'b1;
            else if (wr_ok)                            cfg_err_reg <= 1'b0;
        end
    end

    // Frame FSM with registered frame_done / frame_err
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sof) state_reg <= FRAME;
                end
                FRAME: begin
                    if (sof) begin
                        frame_err_reg <= 1'b1;
                    end else if (eof) begin
                        state_reg      <= DONE;
                        frame_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= sof ? FRAME : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes to the statistics block; every sof starts a fresh count
    logic stat_clr, stat_pix, stat_skin, stat_pub;
    assign stat_clr  = sof;
    assign stat_pix  = (state_reg == FRAME) & ~sof & pix_valid;
    assign stat_skin = stat_pix & skin_mask;
    assign stat_pub  = (state_reg == FRAME) & ~sof & eof;

`ifdef SKIN_STATS_EN
    skin_frame_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .clr        (stat_clr),
        .pix_inc    (stat_pix),
        .skin_inc   (stat_skin),
        .publish    (stat_pub),
        .pix_count  (pix_count),
        .skin_count (skin_count),
        .stats_sat  (stats_sat)
    );
`else
    logic stats_unused;
    assign stats_unused = ^{stat_clr, stat_pix, stat_skin, stat_pub};
    assign pix_count    = '0;
    assign skin_count   = '0;
    assign stats_sat    = 1'b0;
`endif

    assign thr_y_min      = active_reg[ADDR_Y_MIN];
    assign thr_y_max      = active_reg[ADDR_Y_MAX];
    assign thr_cb_min     = active_reg[ADDR_CB_MIN];
    assign thr_cb_max     = active_reg[ADDR_CB_MAX];
    assign thr_cr_min     = active_reg[ADDR_CR_MIN];
    assign thr_cr_max     = active_reg[ADDR_CR_MAX];
    assign commit_pending = pending_reg;
    assign cfg_err        = cfg_err_reg;
    assign frame_err      = frame_err_reg;
    assign frame_done     = frame_done_reg;

endmodule

// File: tb/tb_skin_thresh_ctrl.sv
// Directed bench for skin_thresh_ctrl. Two instances share stimulus: one with
// the default counter width and one with CNT_W=3 to exercise saturation.
// A frame-level model predicts every output each cycle; literal checks pin
// the model at the key points of the scenario.
module tb_skin_thresh_ctrl;

`ifdef SKIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int     W_A   = 19;
    localparam int     W_B   = 3;
    localparam longint MAX_A = (64'd1 << W_A) - 1;
    localparam longint MAX_B = (64'd1 << W_B) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr_valid = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       cfg_commit = 1'b0;
    logic       sof = 1'b0;
    logic       eof = 1'b0;
    logic       pix_valid = 1'b0;
    logic       skin_mask = 1'b0;

    wire [5:0][7:0] thr_a, thr_b;
    wire            pend_a, pend_b, cerr_a, cerr_b, ferr_a, ferr_b;
    wire            done_a, done_b, sat_a, sat_b;
    wire [W_A-1:0]  pix_a, skin_a;
    wire [W_B-1:0]  pix_b, skin_b;

    always #5 clk = ~clk;

    skin_thresh_ctrl #(.CNT_W(W_A)) dut (
        .clk(clk), .rst(rst), .cfg_wr_valid(cfg_wr_valid), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .sof(sof), .eof(eof),
        .pix_valid(pix_valid), .skin_mask(skin_mask),
        .thr_y_min(thr_a[0]), .thr_y_max(thr_a[1]), .thr_cb_min(thr_a[2]),
        .thr_cb_max(thr_a[3]), .thr_cr_min(thr_a[4]), .thr_cr_max(thr_a[5]),
        .commit_pending(pend_a), .cfg_err(cerr_a), .frame_err(ferr_a),
        .frame_done(done_a), .pix_count(pix_a), .skin_count(skin_a),
        .stats_sat(sat_a)
    );

    skin_thresh_ctrl #(.CNT_W(W_B)) dut3 (
        .clk(clk), .rst(rst), .cfg_wr_valid(cfg_wr_valid), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .sof(sof), .eof(eof),
        .pix_valid(pix_valid), .skin_mask(skin_mask),
        .thr_y_min(thr_b[0]), .thr_y_max(thr_b[1]), .thr_cb_min(thr_b[2]),
        .thr_cb_max(thr_b[3]), .thr_cr_min(thr_b[4]), .thr_cr_max(thr_b[5]),
        .commit_pending(pend_b), .cfg_err(cerr_b), .frame_err(ferr_b),
        .frame_done(done_b), .pix_count(pix_b), .skin_count(skin_b),
        .stats_sat(sat_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int     RSTV[6] = '{80, 235, 85, 135, 135, 180};
    int     m_sh[6];
    int     m_act[6];
    bit     m_pend, m_cerr, m_ferr, m_done, m_in_frame, model_live;
    longint m_cnt, m_skin;
    longint p_pix_a, p_skin_a, p_pix_b, p_skin_b;
    bit     p_sat_a, p_sat_b;

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk) begin : model
        bit fire, eset, eclr;
        if (rst) begin
            m_sh = RSTV; m_act = RSTV;
            m_pend = 0; m_cerr = 0; m_ferr = 0; m_done = 0; m_in_frame = 0;
            m_cnt = 0; m_skin = 0;
            p_pix_a = 0; p_skin_a = 0; p_pix_b = 0; p_skin_b = 0;
            p_sat_a = 0; p_sat_b = 0;
            model_live = 1;
        end else begin
            eset = 0; eclr = 0;
            fire = sof && (m_pend || cfg_commit);
            if (fire) begin
                if (m_sh[0] <= m_sh[1] && m_sh[2] <= m_sh[3] && m_sh[4] <= m_sh[5])
                    m_act = m_sh;
                else
                    eset = 1;
                m_pend = 0;
            end else if (cfg_commit) begin
                m_pend = 1;
            end
            if (cfg_wr_valid) begin
                if (cfg_addr < 6) begin
                    m_sh[cfg_addr] = int'(cfg_wdata);
                    eclr = 1;
                end else begin
                    eset = 1;
                end
            end
            if (eset)      m_cerr = 1;
            else if (eclr) m_cerr = 0;

            if (m_done) begin
                m_done = 0;
                if (sof) begin m_in_frame = 1; m_cnt = 0; m_skin = 0; end
            end else if (m_in_frame) begin
                if (sof) begin
                    m_ferr = 1; m_cnt = 0; m_skin = 0;
                end else begin
                    if (pix_valid) begin
                        m_cnt++;
                        if (skin_mask) m_skin++;
                    end
                    if (eof) begin
                        m_in_frame = 0;
                        m_done = 1;
                        if (STATS) begin
                            p_pix_a = lmin(m_cnt, MAX_A); p_skin_a = lmin(m_skin, MAX_A);
                            p_pix_b = lmin(m_cnt, MAX_B); p_skin_b = lmin(m_skin, MAX_B);
                            p_sat_a = (m_cnt > MAX_A) || (m_skin > MAX_A);
                            p_sat_b = (m_cnt > MAX_B) || (m_skin > MAX_B);
                        end
                    end
                end
            end else if (sof) begin
                m_in_frame = 1; m_cnt = 0; m_skin = 0;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("thr_a[%0d]", i), 64'(thr_a[i]), 64'(m_act[i]));
                check($sformatf("thr_b[%0d]", i), 64'(thr_b[i]), 64'(m_act[i]));
            end
            check("pending_a", 64'(pend_a), 64'(m_pend));
            check("pending_b", 64'(pend_b), 64'(m_pend));
            check("cfg_err_a", 64'(cerr_a), 64'(m_cerr));
            check("frame_err_a", 64'(ferr_a), 64'(m_ferr));
            check("frame_done_a", 64'(done_a), 64'(m_done));
            check("frame_done_b", 64'(done_b), 64'(m_done));
            check("pix_a", 64'(pix_a), 64'(p_pix_a));
            check("skin_a", 64'(skin_a), 64'(p_skin_a));
            check("sat_a", 64'(sat_a), 64'(p_sat_a));
            check("pix_b", 64'(pix_b), 64'(p_pix_b));
            check("skin_b", 64'(skin_b), 64'(p_skin_b));
            check("sat_b", 64'(sat_b), 64'(p_sat_b));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        cfg_wr_valid = 1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr_valid = 0;
        $display("write addr=%0d data=%0d", a, d);
    endtask

    task automatic pixel(input bit sk, input bit last);
        pix_valid = 1; skin_mask = sk; eof = last;
        tick();
        pix_valid = 0; skin_mask = 0; eof = 0;
    endtask

    task automatic start_frame();
        sof = 1; tick(); sof = 0;
        $display("sof");
    endtask

    task automatic end_frame_empty();
        eof = 1; tick(); eof = 0;
        tick();
    endtask

    bit pat10[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0};

    initial begin
        tick(); tick();
        rst = 0;
        check("rst_y_min", 64'(thr_a[0]), 64'd80);
        check("rst_cr_max", 64'(thr_a[5]), 64'd180);
        check("rst_pending", 64'(pend_a), 64'd0);
        check("rst_pix", 64'(pix_a), 64'd0);

        // Commit of Y_MIN=100 at sof
        write(3'd0, 8'd100);
        cfg_commit = 1; tick(); cfg_commit = 0;
        check("armed_pending", 64'(pend_a), 64'd1);
        check("pre_sof_y_min", 64'(thr_a[0]), 64'd80);
        start_frame();
        check("post_sof_y_min", 64'(thr_a[0]), 64'd100);
        check("post_sof_pending", 64'(pend_a), 64'd0);
        end_frame_empty();

        // Invalid Cb bounds are rejected
        write(3'd2, 8'd150);
        write(3'd3, 8'd120);
        cfg_commit = 1; tick(); cfg_commit = 0;
        start_frame();
        check("bad_cb_min", 64'(thr_a[2]), 64'd85);
        check("bad_cb_max", 64'(thr_a[3]), 64'd135);
        check("bad_cfg_err", 64'(cerr_a), 64'd1);
        write(3'd0, 8'd100);
        check("cfg_err_cleared", 64'(cerr_a), 64'd0);
        write(3'd2, 8'd85);
        write(3'd3, 8'd135);
        end_frame_empty();

        // 10 pixels, 4 skin, eof on the last
        start_frame();
        for (int i = 0; i < 10; i++) pixel(pat10[i], i == 9);
        $display("frame 10 px / 4 skin done");
        check("f10_done", 64'(done_a), 64'd1);
        check("f10_pix", 64'(pix_a), STATS ? 64'd10 : 64'd0);
        check("f10_skin", 64'(skin_a), STATS ? 64'd4 : 64'd0);
        check("f10_pix_w3", 64'(pix_b), STATS ? 64'd7 : 64'd0);
        tick();
        check("f10_done_low", 64'(done_a), 64'd0);
        check("f10_pix_hold", 64'(pix_a), STATS ? 64'd10 : 64'd0);

        // Missing eof restarts the frame
        start_frame();
        for (int i = 0; i < 3; i++) pixel(1'b0, 1'b0);
        start_frame();
        for (int i = 0; i < 5; i++) pixel(1'b1, i == 4);
        $display("restarted frame done");
        check("restart_frame_err", 64'(ferr_a), 64'd1);
        check("restart_pix", 64'(pix_a), STATS ? 64'd5 : 64'd0);
        tick();

        // Commit, Y_MAX write and sof together
        cfg_commit = 1; cfg_wr_valid = 1; cfg_addr = 3'd1; cfg_wdata = 8'd200; sof = 1;
        tick();
        cfg_commit = 0; cfg_wr_valid = 0; sof = 0;
        $display("commit+write+sof");
        check("same_cycle_y_max", 64'(thr_a[1]), 64'd235);
        check("same_cycle_pending", 64'(pend_a), 64'd0);
        cfg_commit = 1; sof = 1; tick(); cfg_commit = 0; sof = 0;
        check("shadow_y_max", 64'(thr_a[1]), 64'd200);
        end_frame_empty();

        // Saturation on the narrow instance
        start_frame();
        for (int i = 0; i < 9; i++) pixel(1'b1, i == 8);
        $display("frame 9 skin px done");
        check("sat_pix_w3", 64'(pix_b), STATS ? 64'd7 : 64'd0);
        check("sat_skin_w3", 64'(skin_b), STATS ? 64'd7 : 64'd0);
        check("sat_flag_w3", 64'(sat_b), STATS ? 64'd1 : 64'd0);
        check("sat_pix_wide", 64'(pix_a), STATS ? 64'd9 : 64'd0);
        check("sat_flag_wide", 64'(sat_a), 64'd0);
        check("sat_done_w3", 64'(done_b), 64'd1);
        tick();

        // Back-to-back frames: sof in the DONE cycle
        start_frame();
        for (int i = 0; i < 2; i++) pixel(1'b0, i == 1);
        start_frame();
        for (int i = 0; i < 3; i++) pixel(1'b1, i == 2);
        $display("back-to-back frame done");
        check("b2b_done", 64'(done_a), 64'd1);
        check("b2b_pix", 64'(pix_a), STATS ? 64'd3 : 64'd0);
        tick();

        // Unmapped address, double commit, then reset mid-frame
        write(3'd6, 8'd1);
        check("bad_addr_err", 64'(cerr_a), 64'd1);
        cfg_commit = 1; tick(); tick(); cfg_commit = 0;
        check("double_commit", 64'(pend_a), 64'd1);
        write(3'd0, 8'd50);
        start_frame();
        check("commit_y_min_50", 64'(thr_a[0]), 64'd50);
        pixel(1'b1, 1'b0);
        pixel(1'b1, 1'b0);
        write(3'd5, 8'd190);
        cfg_commit = 1; tick(); cfg_commit = 0;
        rst = 1; tick(); rst = 0;
        $display("reset mid-frame");
        check("mid_rst_pending", 64'(pend_a), 64'd0);
        check("mid_rst_y_min", 64'(thr_a[0]), 64'd80);
        check("mid_rst_ferr", 64'(ferr_a), 64'd0);
        eof = 1; tick(); eof = 0;
        check("mid_rst_no_done", 64'(done_a), 64'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/skin_thresh_ctrl.md
# skin_thresh_ctrl

Frame-synchronous controller for the YCbCr skin-detection stage. Holds host-writable shadow copies of the six Y/Cb/Cr threshold bounds and commits them atomically to the active threshold outputs at a start-of-frame. It also counts valid and skin pixels per frame and publishes the totals at end-of-frame. It sits between the host configuration path and the skin detector, and its statistics feed the gesture logic downstream.

## Interface
Parameters:
- `Y_MIN_RST`, default 80: reset value of the active and shadow Y lower bound.
- `Y_MAX_RST`, default 235: reset value of the Y upper bound.
- `CB_MIN_RST`, default 85: reset value of the Cb lower bound.
- `CB_MAX_RST`, default 135: reset value of the Cb upper bound.
- `CR_MIN_RST`, default 135: reset value of the Cr lower bound.
- `CR_MAX_RST`, default 180: reset value of the Cr upper bound.
- `CNT_W`, default 19: width of the pixel counters (covers 640x480).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_wr_valid`  in  1  shadow-register write strobe.
- `cfg_addr`  in  3  register select: 0 Y_MIN, 1 Y_MAX, 2 CB_MIN, 3 CB_MAX, 4 CR_MIN, 5 CR_MAX.
- `cfg_wdata`  in  8  write data.
- `cfg_commit`  in  1  pulse that requests a shadow-to-active copy at the next `sof`.
- `sof`  in  1  start-of-frame pulse; no pixel is valid in this cycle.
- `eof`  in  1  end-of-frame pulse; coincides with the last pixel.
- `pix_valid`  in  1  detector output valid.
- `skin_mask`  in  1  detector skin flag.
- `thr_y_min`, `thr_y_max`, `thr_cb_min`, `thr_cb_max`, `thr_cr_min`, `thr_cr_max`  out  8 each  active thresholds.
- `commit_pending`  out  1  a commit is armed.
- `cfg_err`  out  1  sticky error flag.
- `frame_err`  out  1  sticky error flag.
- `frame_done`  out  1  one-cycle pulse.
- `pix_count`  out  CNT_W  published valid-pixel count.
- `skin_count`  out  CNT_W  published skin-pixel count.
- `stats_sat`  out  1  a published count saturated.

## Operation
- **Reset values:** active and shadow thresholds take the `*_RST` values. All flags, counts and `frame_done` are 0. The state is IDLE.
- **Shadow writes:** `cfg_wr_valid` with address 0–5 writes the shadow register. Addresses 6–7 are ignored and set `cfg_err`. The host cannot read back, and writes are always accepted.
- **Arming a commit:** `cfg_commit` sets `commit_pending`. A second `cfg_commit` while pending has no additional effect.
- **Commit on `sof`** (any state) with pending set:
  - If every min ≤ its max, all six active registers load from the shadow registers together.
  - Otherwise the active registers are unchanged and `cfg_err` is set.
  - In both cases pending clears.
- **Simultaneous events:**
  - `cfg_commit` in the same cycle as `sof` is applied at that `sof`.
  - A shadow write in the same cycle as the commit lands after the copy; the active registers receive the pre-write value.
- **Clearing `cfg_err`:** cleared by the next valid-address write. `frame_err` is cleared only by reset.
- **FSM states:** IDLE, FRAME, DONE.
  - IDLE: `sof` → FRAME and clear the working counters. `eof` and pixels are ignored.
  - FRAME: `pix_valid` increments the pixel counter. `pix_valid & skin_mask` increments the skin counter. Both counters saturate at all-ones and set a working saturation bit.
  - FRAME, `eof`: include any pixel in that same cycle, then go to DONE.
  - FRAME, `sof` (missing `eof`): set `frame_err`, clear the counters, stay in FRAME, and publish nothing.
  - DONE: `frame_done` = 1. `pix_count`, `skin_count` and `stats_sat` load the working values and hold until the next DONE. Next state is IDLE, or FRAME if `sof` arrives in this cycle.
- **Reset mid-frame:** everything returns to its reset value, pending is dropped, and there is no `frame_done`.

## Timing
- New active thresholds are visible in the cycle after the `sof` edge, ahead of the first pixel of that frame.
- `frame_done` and the updated stats appear in the cycle after the `eof` cycle. Latency is 1.
- Back-to-back frames are allowed: `sof` is accepted as early as the DONE cycle.
- The counters are CNT_W-bit unsigned with no wrap.

## Configuration
- `SKIN_STATS_EN` defined: pixel and skin counters, `pix_count`, `skin_count` and `stats_sat` operate as described.
- `SKIN_STATS_EN` undefined: the counters are removed and those outputs are tied to 0. The FSM, `frame_done`, `frame_err` and all threshold logic are unchanged.
- All ports are present in both builds.

## Structure
- Shared package `skin_pkg`:
  - register address constants;
  - default threshold constants;
  - `CNT_W`;
  - FSM state enum (IDLE/FRAME/DONE).
- Sub-module `skin_frame_stats`: working counters, saturation and publish registers. Inputs are clear/count/publish strobes from the FSM. Compiled only under `SKIN_STATS_EN`.

## Test plan
- Reset, then write Y_MIN=100 with `cfg_commit`, then `sof` → `thr_y_min` reads 80 before `sof` and 100 the cycle after; `commit_pending` goes 1 then 0.
- Shadow CB_MIN=150, CB_MAX=120, commit, `sof` → active Cb stays 85/135; `cfg_err`=1; a following write to address 0 clears it.
- Frame of 10 valid pixels, 4 with skin, with `eof` on pixel 10 → `frame_done` pulses 1 cycle after `eof`; `pix_count`=10, `skin_count`=4.
- `sof`, 3 pixels, then `sof` again without `eof`, then 5 pixels and `eof` → `frame_err`=1; `pix_count`=5.
- `cfg_commit` and a write of Y_MAX=200 in the same cycle as `sof` → active Y_MAX keeps the pre-write shadow value; shadow holds 200; pending=0.
- With `CNT_W`=3, 9 skin pixels → `pix_count`=7, `skin_count`=7, `stats_sat`=1. With `SKIN_STATS_EN` undefined → counts 0 and `frame_done` still pulses.
